// File: rtl/ipif_reg_master_pkg.sv
// Shared definitions for the IPIF register initiator and the peripherals that
// decode its chip enables (index i drives CE bit [N-1-i]).
package ipif_reg_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } ipif_state_e;

  localparam int CE_MAX = 32;

  // Out-of-range indices map to an all-zero CE vector.
  function automatic logic [CE_MAX-1:0] idx_to_ce(input int idx, input int num_reg);
    logic [CE_MAX-1:0] ce;
    if (idx < num_reg) begin
      ce = {{(CE_MAX-1){1'b0}}, 1'b1} << (num_reg - 1 - idx);
    end else begin
      ce = '0;
    end
    return ce;
  endfunction

endpackage

// File: rtl/ipif_reg_master_if.sv
// IPIF register bus between one initiator (Bus2IP_* driver) and a user_logic slave.
interface ipif_reg_master_if #(
  parameter int C_SLV_DWIDTH = 32,
  parameter int C_NUM_REG    = 2
);
  logic [C_SLV_DWIDTH-1:0]   Bus2IP_Data;
  logic [C_SLV_DWIDTH/8-1:0] Bus2IP_BE;
  logic [C_NUM_REG-1:0]      Bus2IP_RdCE;
  logic [C_NUM_REG-1:0]      Bus2IP_WrCE;
  logic [C_SLV_DWIDTH-1:0]   IP2Bus_Data;
  logic                      IP2Bus_RdAck;
  logic                      IP2Bus_WrAck;
  logic                      IP2Bus_Error;

  modport master (
    output Bus2IP_Data, Bus2IP_BE, Bus2IP_RdCE, Bus2IP_WrCE,
    input  IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
  );

  modport slave (
    input  Bus2IP_Data, Bus2IP_BE, Bus2IP_RdCE, Bus2IP_WrCE,
    output IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
  );
endinterface

// File: rtl/ipif_timeout_cntr.sv
// Ack-wait counter: expired_o is high in the C_TIMEOUT-th cycle after a clear.
// C_TIMEOUT = 0 never expires.
module ipif_timeout_cntr #(
  parameter int C_TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CW = (C_TIMEOUT > 1) ? $clog2(C_TIMEOUT) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expired_o = (C_TIMEOUT != 0) && (cnt_q == CW'(C_TIMEOUT - 1));

  // Saturate at the terminal count so the flag cannot wrap away.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/ipif_reg_master.sv
// IPIF bus initiator: turns one valid/ready register command into one IPIF
// access and returns the outcome on a valid/ready response stream.
module ipif_reg_master
  import ipif_reg_master_pkg::*;
#(
  parameter int C_SLV_DWIDTH = 32,
  parameter int C_NUM_REG    = 2,
  parameter int C_TIMEOUT    = 16,
  parameter int C_IDX_W      = (C_NUM_REG > 1) ? $clog2(C_NUM_REG) : 1
) (
  input  logic                      Bus2IP_Clk,
  input  logic                      Bus2IP_Resetn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_wr,
  input  logic [C_IDX_W-1:0]        cmd_idx,
  input  logic [C_SLV_DWIDTH-1:0]   cmd_data,
  input  logic [C_SLV_DWIDTH/8-1:0] cmd_be,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [C_SLV_DWIDTH-1:0]   rsp_data,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  ipif_reg_master_if.master         bus_if
);
  ipif_state_e               state_q, state_d;
  logic                      wr_q, wr_d;
  logic [C_NUM_REG-1:0]      rdce_q, rdce_d, wrce_q, wrce_d;
  logic [C_SLV_DWIDTH-1:0]   data_q, data_d, rsp_data_q, rsp_data_d;
  logic [C_SLV_DWIDTH/8-1:0] be_q, be_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic                      rsp_err_q, rsp_err_d;
  logic                      rsp_timeout_q, rsp_timeout_d;
  logic [C_NUM_REG-1:0]      ce_s;
  logic                      ack_s, expired_s, cntr_clr_s, cntr_en_s;

  assign ce_s  = C_NUM_REG'(idx_to_ce(32'(cmd_idx), C_NUM_REG));
  assign ack_s = wr_q ? bus_if.IP2Bus_WrAck : bus_if.IP2Bus_RdAck;

  assign cmd_ready          = (state_q == IDLE) && Bus2IP_Resetn;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_data           = rsp_data_q;
  assign rsp_err            = rsp_err_q;
  assign rsp_timeout        = rsp_timeout_q;
  assign bus_if.Bus2IP_Data = data_q;
  assign bus_if.Bus2IP_BE   = be_q;
  assign bus_if.Bus2IP_RdCE = rdce_q;
  assign bus_if.Bus2IP_WrCE = wrce_q;

  ipif_timeout_cntr #(.C_TIMEOUT(C_TIMEOUT)) u_tmo (
    .clk_i     (Bus2IP_Clk),
    .rst_ni    (Bus2IP_Resetn),
    .clr_i     (cntr_clr_s),
    .en_i      (cntr_en_s),
    .expired_o (expired_s)
  );

  // Bus outputs are cleared on the same edge that ends an access.
  always_comb begin
    state_d       = state_q;
    wr_d          = wr_q;
    rdce_d        = rdce_q;
    wrce_d        = wrce_q;
    data_d        = data_q;
    be_d          = be_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    cntr_clr_s    = 1'b0;
    cntr_en_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          wr_d = cmd_wr;
          if (ce_s != '0) begin
            rdce_d     = cmd_wr ? '0 : ce_s;
            wrce_d     = cmd_wr ? ce_s : '0;
            be_d       = cmd_be;
            data_d     = cmd_wr ? cmd_data : '0;
            cntr_clr_s = 1'b1;
            state_d    = ACCESS;
          end else begin
            rsp_valid_d   = 1'b1;
            rsp_data_d    = '0;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b0;
            state_d       = RESP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (ack_s) begin
          rsp_valid_d   = 1'b1;
          rsp_data_d    = wr_q ? '0 : bus_if.IP2Bus_Data;
          rsp_err_d     = bus_if.IP2Bus_Error;
          rsp_timeout_d = 1'b0;
          rdce_d        = '0;
          wrce_d        = '0;
          data_d        = '0;
          be_d          = '0;
          state_d       = RESP;
        end else if (expired_s) begin
          rsp_valid_d   = 1'b1;
          rsp_data_d    = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rdce_d        = '0;
          wrce_d        = '0;
          data_d        = '0;
          be_d          = '0;
          state_d       = RESP;
        end else begin
          cntr_en_s = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        rdce_d      = '0;
        wrce_d      = '0;
        data_d      = '0;
        be_d        = '0;
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge Bus2IP_Clk) begin
    if (!Bus2IP_Resetn) begin
      state_q       <= IDLE;
      wr_q          <= 1'b0;
      rdce_q        <= '0;
      wrce_q        <= '0;
      data_q        <= '0;
      be_q          <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_q          <= wr_d;
      rdce_q        <= rdce_d;
      wrce_q        <= wrce_d;
      data_q        <= data_d;
      be_q          <= be_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end
endmodule
